// File: rtl/systolic_feeder.sv
// Feeds one weight tile and a stream of skewed activation vectors into a
// ROWS x COLS systolic array; all outputs come straight from flops.
module systolic_feeder #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          num_vecs,
    input  logic                 mode_fp16_in,
    input  logic                 signed_mode_in,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [COLS*DW-1:0]   w_data,
    input  logic                 act_valid,
    output logic                 act_ready,
    input  logic [ROWS*DW-1:0]   act_data,
    output logic                 mode_fp16,
    output logic                 signed_mode,
    output logic [ROWS-1:0]      load_b,
    output logic [COLS*DW-1:0]   b_out,
    output logic [ROWS*DW-1:0]   a_out,
    output logic [ROWS-1:0]      a_valid,
    output logic                 busy,
    output logic                 done
);

    // state  | meaning
    // IDLE   | waiting for start
    // LOAD_W | accepting ROWS weight rows, one load_b strobe per row
    // STREAM | accepting num_vecs activation vectors
    // FLUSH  | ROWS cycles draining the skew pipeline
    // DONE   | one-cycle done pulse
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_W = 3'd1;
    localparam logic [2:0] STREAM = 3'd2;
    localparam logic [2:0] FLUSH  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      w_cnt_q, w_cnt_d;
    logic [CW-1:0]      flush_cnt_q, flush_cnt_d;
    logic [15:0]        vec_cnt_q, vec_cnt_d;
    logic [15:0]        nv_q, nv_d;
    logic               mode_fp16_q, mode_fp16_d;
    logic               signed_q, signed_d;
    logic [ROWS-1:0]    load_b_q, load_b_d;
    logic [COLS*DW-1:0] b_out_q, b_out_d;
    logic               w_ready_q, act_ready_q, busy_q, done_q;
    logic               w_acc, act_acc;

    assign w_acc   = (state_q == LOAD_W) && w_valid;
    assign act_acc = (state_q == STREAM) && act_valid;

    always_comb begin
        state_d     = state_q;
        w_cnt_d     = w_cnt_q;
        flush_cnt_d = flush_cnt_q;
        vec_cnt_d   = vec_cnt_q;
        nv_d        = nv_q;
        mode_fp16_d = mode_fp16_q;
        signed_d    = signed_q;
        load_b_d    = '0;
        b_out_d     = b_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD_W;
                    nv_d        = num_vecs;
                    mode_fp16_d = mode_fp16_in;
                    signed_d    = signed_mode_in;
                    w_cnt_d     = '0;
                    vec_cnt_d   = '0;
                    flush_cnt_d = '0;
                end
            end
            LOAD_W: begin
                if (w_acc) begin
                    load_b_d[w_cnt_q] = 1'b1;
                    b_out_d           = w_data;
                    w_cnt_d           = w_cnt_q + 1'b1;
                    if (w_cnt_q == LAST_ROW) begin
                        state_d = (nv_q == 16'd0) ? DONE : STREAM;
                    end
                end
            end
            STREAM: begin
                if (act_acc) begin
                    vec_cnt_d = vec_cnt_q + 16'd1;
                    // nv_q is nonzero here, so nv_q-1 never wraps
                    if (vec_cnt_q == nv_q - 16'd1) begin
                        state_d     = FLUSH;
                        flush_cnt_d = LAST_ROW;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            w_cnt_q     <= '0;
            flush_cnt_q <= '0;
            vec_cnt_q   <= '0;
            nv_q        <= '0;
            mode_fp16_q <= 1'b0;
            signed_q    <= 1'b0;
            load_b_q    <= '0;
            b_out_q     <= '0;
            w_ready_q   <= 1'b0;
            act_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_cnt_q     <= w_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            vec_cnt_q   <= vec_cnt_d;
            nv_q        <= nv_d;
            mode_fp16_q <= mode_fp16_d;
            signed_q    <= signed_d;
            load_b_q    <= load_b_d;
            b_out_q     <= b_out_d;
            w_ready_q   <= (state_d == LOAD_W);
            act_ready_q <= (state_d == STREAM);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    // Row r is a delay line of r+1 flops; idle cycles inject zero bubbles.
    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        logic [DW-1:0] dl_q [0:r];
        logic [r:0]    vl_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= r; j++) dl_q[j] <= '0;
                vl_q <= '0;
            end else begin
                dl_q[0] <= act_acc ? act_data[r*DW +: DW] : '0;
                vl_q[0] <= act_acc;
                for (int j = 1; j <= r; j++) begin
                    dl_q[j] <= dl_q[j-1];
                    vl_q[j] <= vl_q[j-1];
                end
            end
        end

        assign a_out[r*DW +: DW] = dl_q[r];
        assign a_valid[r]        = vl_q[r];
    end

    assign w_ready     = w_ready_q;
    assign act_ready   = act_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign load_b      = load_b_q;
    assign b_out       = b_out_q;
    assign mode_fp16   = mode_fp16_q;
    assign signed_mode = signed_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with ROWS=COLS=4, DW=16.
module tb_systolic_feeder;

    logic        clk = 1'b0;
    logic        rst, start, mode_fp16_in, signed_mode_in;
    logic [15:0] num_vecs;
    logic        w_valid, w_ready, act_valid, act_ready;
    logic [63:0] w_data, act_data, b_out, a_out;
    logic        mode_fp16, signed_mode, busy, done;
    logic [3:0]  load_b, a_valid;

    int total = 0;
    int bad   = 0;
    int inj [0:15];

    always #5 clk = ~clk;

    systolic_feeder #(.ROWS(4), .COLS(4), .DW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vecs(num_vecs),
        .mode_fp16_in(mode_fp16_in), .signed_mode_in(signed_mode_in),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .mode_fp16(mode_fp16), .signed_mode(signed_mode),
        .load_b(load_b), .b_out(b_out), .a_out(a_out), .a_valid(a_valid),
        .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] vword(int v, int r);
        return 16'(32'hA000 + v * 16 + r);
    endfunction

    function automatic logic [63:0] vec(int v);
        logic [63:0] x;
        for (int r = 0; r < 4; r++) x[r*16 +: 16] = vword(v, r);
        return x;
    endfunction

    function automatic logic [63:0] wrow(int k);
        logic [63:0] x;
        for (int c = 0; c < 4; c++) x[c*16 +: 16] = 16'(32'hB000 + k * 256 + c);
        return x;
    endfunction

    // inj[i] = vector index accepted i cycles after t, or -1 for none
    task automatic check_skew(input int k, input string tag);
        logic [63:0] ea;
        logic [3:0]  ev;
        ea = '0;
        ev = '0;
        for (int r = 0; r < 4; r++) begin
            if (k - 1 - r >= 0 && k - 1 - r < 16 && inj[k-1-r] >= 0) begin
                ea[r*16 +: 16] = vword(inj[k-1-r], r);
                ev[r]          = 1'b1;
            end
        end
        chk({tag, "_a_out"}, a_out, ea);
        chk({tag, "_a_valid"}, {60'd0, a_valid}, {60'd0, ev});
    endtask

    task automatic clear_inj();
        for (int i = 0; i < 16; i++) inj[i] = -1;
    endtask

    task automatic start_tile(input int nv, input logic fp, input logic sg);
        start = 1'b1; num_vecs = 16'(nv); mode_fp16_in = fp; signed_mode_in = sg;
        tick();
        start = 1'b0; mode_fp16_in = 1'b0; signed_mode_in = 1'b0; num_vecs = 16'd0;
        chk("start_w_ready", {63'd0, w_ready}, 64'd1);
        chk("start_busy", {63'd0, busy}, 64'd1);
    endtask

    task automatic run_weights();
        for (int k = 0; k < 4; k++) begin
            w_valid = 1'b1;
            w_data  = wrow(k);
            tick();
            chk("load_b", {60'd0, load_b}, 64'(4'b0001 << k));
            chk("b_out", b_out, wrow(k));
        end
        w_valid = 1'b0;
        w_data  = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_load_b"}, {60'd0, load_b}, 64'd0);
        chk({tag, "_b_out"}, b_out, 64'd0);
        chk({tag, "_a_out"}, a_out, 64'd0);
        chk({tag, "_a_valid"}, {60'd0, a_valid}, 64'd0);
        chk({tag, "_flags"}, {58'd0, w_ready, act_ready, busy, done, mode_fp16, signed_mode}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_vecs = '0; mode_fp16_in = 1'b0; signed_mode_in = 1'b0;
        w_valid = 1'b0; w_data = '0; act_valid = 1'b0; act_data = '0;
        clear_inj();
        tick(); tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Tile A: two back-to-back vectors
        start_tile(2, 1'b1, 1'b0);
        chk("A_mode_fp16", {63'd0, mode_fp16}, 64'd1);
        run_weights();
        chk("A_act_ready", {63'd0, act_ready}, 64'd1);
        clear_inj(); inj[0] = 0; inj[1] = 1;
        act_valid = 1'b1; act_data = vec(0);
        tick();
        act_data = vec(1);
        check_skew(1, "A_k1");
        chk("A_load_b_idle", {60'd0, load_b}, 64'd0);
        tick();
        act_valid = 1'b0; act_data = '0;
        for (int k = 2; k <= 5; k++) begin
            check_skew(k, "A_flush");
            chk("A_flush_act_ready", {63'd0, act_ready}, 64'd0);
            chk("A_flush_done", {63'd0, done}, 64'd0);
            tick();
        end
        chk("A_done", {62'd0, done, busy}, 64'd3);
        chk("A_done_a_valid", {60'd0, a_valid}, 64'd0);
        tick();
        chk("A_after", {62'd0, done, busy}, 64'd0);
        chk("A_mode_held", {63'd0, mode_fp16}, 64'd1);

        // Tile B: bubble between vectors
        start_tile(2, 1'b0, 1'b0);
        run_weights();
        clear_inj(); inj[0] = 0; inj[2] = 1;
        act_valid = 1'b1; act_data = vec(0);
        tick();
        act_valid = 1'b0; act_data = '0;
        check_skew(1, "B_k1");
        chk("B_gap_act_ready", {63'd0, act_ready}, 64'd1);
        tick();
        act_valid = 1'b1; act_data = vec(1);
        check_skew(2, "B_k2");
        tick();
        act_valid = 1'b0; act_data = '0;
        for (int k = 3; k <= 6; k++) begin
            check_skew(k, "B_skew");
            chk("B_row2", {63'd0, a_valid[2]}, (k == 4 || k == 6) ? 64'd0 : 64'd1);
            tick();
        end
        chk("B_done", {62'd0, done, busy}, 64'd3);
        tick();

        // Tile C: zero vectors, start re-asserted while stalled in LOAD_W
        start_tile(0, 1'b0, 1'b1);
        start = 1'b1; num_vecs = 16'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("C_stall_load_b", {60'd0, load_b}, 64'd0);
            chk("C_stall_ready", {62'd0, w_ready, busy}, 64'd3);
        end
        start = 1'b0; num_vecs = 16'd0;
        run_weights();
        chk("C_done", {62'd0, done, act_ready}, 64'd2);
        chk("C_modes", {62'd0, mode_fp16, signed_mode}, 64'd1);
        tick();
        chk("C_after", {60'd0, done, busy, act_ready, signed_mode}, 64'd1);
        chk("C_a_valid", {60'd0, a_valid}, 64'd0);

        // Tile D: reset mid-stream, then a fresh single-vector tile
        start_tile(3, 1'b1, 1'b1);
        run_weights();
        act_valid = 1'b1; act_data = vec(0);
        tick();
        rst = 1'b1; start = 1'b1; num_vecs = 16'd5;
        tick();
        check_reset_vals("D_reset");
        rst = 1'b0; start = 1'b0; act_valid = 1'b0; act_data = '0;
        start_tile(1, 1'b0, 1'b0);
        run_weights();
        clear_inj(); inj[0] = 2;
        act_valid = 1'b1; act_data = vec(2);
        tick();
        act_valid = 1'b0; act_data = '0;
        for (int k = 1; k <= 4; k++) begin
            check_skew(k, "D_skew");
            tick();
        end
        chk("D_done", {62'd0, done, busy}, 64'd3);
        tick();
        chk("D_after", {62'd0, done, busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter: ROWS, 4, number of PE rows fed (>=2).
REQ-002 Parameter: COLS, 4, number of PE columns.
REQ-003 Parameter: DW, 16, word width (fp16/int8-in-16 operand).
REQ-004 Port: clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: rst  in  1  reset is synchronous and active-high.
REQ-006 Port: start  in  1  begin one tile; sampled in IDLE only.
REQ-007 Port: num_vecs  in  16  activation vectors in tile; latched on start.
REQ-008 Port: mode_fp16_in, signed_mode_in  in  1 each  tile mode; latched on start.
REQ-009 Port: w_valid / w_ready  in / out  1 each  weight-row handshake.
REQ-010 Port: w_data  in  COLS*DW  one weight row; column c at bits [c*DW +: DW].
REQ-011 Port: act_valid / act_ready  in / out  1 each  activation handshake.
REQ-012 Port: act_data  in  ROWS*DW  one activation vector; row r at [r*DW +: DW].
REQ-013 Port: mode_fp16, signed_mode  out  1 each  latched modes driven to array.
REQ-014 Port: load_b  out  ROWS  one-hot per-row weight-load strobe.
REQ-015 Port: b_out  out  COLS*DW  weight row presented with load_b.
REQ-016 Port: a_out  out  ROWS*DW  skewed activations into row r of array.
REQ-017 Port: a_valid  out  ROWS  per-row qualifier for a_out.
REQ-018 Port: busy  out  1  high in any state except IDLE.
REQ-019 Port: done  out  1  one-cycle pulse at tile end.

Function
REQ-020 FSM states SHALL be IDLE, LOAD_W, STREAM, FLUSH, DONE; all outputs registered.
REQ-021 IDLE: start=1 latches num_vecs and modes, clears counters, next state LOAD_W; start ignored elsewhere.
REQ-022 w_ready SHALL be 1 only in LOAD_W; act_ready SHALL be 1 only in STREAM.
REQ-023 k-th accepted weight beat (k=0..ROWS-1) SHALL produce, next cycle, load_b=1<<k and b_out=w_data for exactly one cycle; otherwise load_b=0, b_out holds.
REQ-024 After beat ROWS-1 accepted: next state STREAM, or DONE if num_vecs==0 (no FLUSH).
REQ-025 Skew: vector accepted in cycle t SHALL drive a_out row r with act_data row r and a_valid[r]=1 in cycle t+1+r.
REQ-026 Skew pipeline SHALL shift every cycle; cycles without an accepted vector inject zero data with a_valid=0 at row 0 (bubbles preserved per row).
REQ-027 STREAM counts accepted vectors; on acceptance of vector num_vecs-1 next state FLUSH.
REQ-028 FLUSH SHALL last exactly ROWS cycles, w_ready=act_ready=0, pipeline shifting; then DONE.
REQ-029 DONE SHALL last one cycle with done=1, busy=1, then IDLE; done=0 in all other states.
REQ-030 Vector count SHALL be 16-bit unsigned; num_vecs=65535 supported without wrap.
REQ-031 mode_fp16/signed_mode outputs SHALL hold latched values until next start.
REQ-032 No downstream backpressure: array consumes a_out every cycle.

Reset
REQ-033 rst=1 SHALL force IDLE regardless of state, including mid-LOAD_W or mid-STREAM, discarding in-flight data.
REQ-034 Reset values: load_b=0, b_out=0, a_out=0, a_valid=0, w_ready=0, act_ready=0, busy=0, done=0, mode_fp16=0, signed_mode=0, counters=0.
REQ-035 Reset SHALL take priority over start and any handshake in the same cycle.

Verification
REQ-036 ROWS=COLS=4, start num_vecs=2, weight rows W0..W3 back-to-back -> load_b 0001,0010,0100,1000 on consecutive cycles with b_out=W0..W3.
REQ-037 Vectors V0 (cycle t), V1 (t+1) -> row r shows V0[r] at t+1+r, V1[r] at t+2+r; FLUSH 4 cycles; done pulses once at t+6, then busy=0.
REQ-038 act_valid gap: V0 at t, V1 at t+2 -> a_valid[2] high at t+3, low at t+4, high at t+5.
REQ-039 num_vecs=0 -> after 4 weight beats, done pulse next cycle, act_ready never asserted, a_valid stays 0.
REQ-040 rst asserted during STREAM after 1 of 3 vectors -> next cycle all outputs at reset values, IDLE; new start then runs full tile correctly.
REQ-041 start asserted while busy and w_valid held low in LOAD_W -> start ignored, state held, load_b=0 until weights arrive.
